// File: rtl/clk_div_seq_pkg.sv
// clk_div_seq_pkg: shared types and defaults for the clk_div_seq divider.
//   state_t       : sequencer states (IDLE, RUN)
//   DIV_W_DEF     : default width of the ratio field
//   DEF_RATIO_DEF : default ratio loaded at reset (R=1 -> period of 4 clk)
package clk_div_seq_pkg;
  localparam int DIV_W_DEF     = 8;
  localparam int DEF_RATIO_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/clk_div_seq_core.sv
// clk_div_seq_core: phase counter and out_clk toggle.
//   clk, reset : clock, async active-high reset
//   run        : divider should be running in the coming cycle
//   ratio      : R; each out_clk phase lasts R+1 clk cycles
//   out_clk    : registered divided clock
//   boundary   : last cycle of a low phase while running (period end)
module clk_div_seq_core
  import clk_div_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] ratio,
  output logic             out_clk,
  output logic             boundary
);
  logic             active;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      cnt     <= '0;
      out_clk <= 1'b0;
    end else begin
      active <= run;
      if (!run) begin
        cnt     <= '0;
        out_clk <= 1'b0;
      end else if (!active) begin
        // first running cycle always starts a fresh high phase
        cnt     <= '0;
        out_clk <= 1'b1;
      end else if (cnt == ratio) begin
        cnt     <= '0;
        out_clk <= ~out_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign boundary = active & ~out_clk & (cnt == ratio);
endmodule

// File: rtl/clk_div_seq.sv
// clk_div_seq: programmable clock divider with ratio handshake.
//   clk, reset  : clock, async active-high reset
//   en          : level request to run; sampled only at period boundaries
//   cfg_valid   : new ratio offered
//   cfg_ratio   : offered ratio R (phase = R+1 cycles)
//   cfg_ready   : no ratio pending, new one can be accepted
//   out_clk     : registered divided clock
//   period_done : one-cycle pulse after each completed period
//   busy        : sequencer in RUN
//   period_cnt  : (only with CLK_DIV_SEQ_CNT_EN) 16-bit count of periods
module clk_div_seq
  import clk_div_seq_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DEF_RATIO = DEF_RATIO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             out_clk,
  output logic             period_done,
`ifdef CLK_DIV_SEQ_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);
  state_t           state_q, state_d;
  logic             pend_q;
  logic [DIV_W-1:0] pend_val;
  logic [DIV_W-1:0] r_q;
  logic             boundary;
  logic             run;
  logic             accept;
  logic             apply;

  // ratio changes only land between periods; in IDLE there is no period
  // to protect, so a pending ratio lands right away
  assign accept = cfg_valid & ~pend_q;
  assign apply  = pend_q & (boundary | (state_q == IDLE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (boundary && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run = (state_d == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_val    <= '0;
      r_q         <= DIV_W'(DEF_RATIO);
      period_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_done <= boundary;
      if (accept) begin
        pend_q   <= 1'b1;
        pend_val <= cfg_ratio;
      end else if (apply) begin
        pend_q <= 1'b0;
        r_q    <= pend_val;
      end
    end
  end

  assign cfg_ready = ~pend_q;
  assign busy      = (state_q == RUN);

  clk_div_seq_core #(.DIV_W(DIV_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .ratio    (r_q),
    .out_clk  (out_clk),
    .boundary (boundary)
  );

`ifdef CLK_DIV_SEQ_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            period_cnt <= '0;
    else if (period_done) period_cnt <= period_cnt + 16'd1;
  end
`endif
endmodule
